multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle opcode decoder.
- FSM steps each instruction through fetch, decode, execute, memory and writeback over several cycles.
- Stalls on a memory ready handshake.
- Owns the CPSR flag register, including its update and clear policy.
- Sits between the instruction register opcode field and the shared-datapath muxes, register file, ALU and memory port.

---
 rtl/mc_pkg.sv | 74 +++++++
 rtl/mc_opcode_decode.sv | 31 +++
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_pkg
//  Description : Shared encodings for the multi-cycle controller: opcodes,
//                instruction classes, FSM states, mux selects, flag indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

   // Opcode field values (IR[31:26])
   localparam logic [5:0] c_op_r    = 6'h00;
   localparam logic [5:0] c_op_j    = 6'h02;
   localparam logic [5:0] c_op_beq  = 6'h04;
   localparam logic [5:0] c_op_addi = 6'h08;
   localparam logic [5:0] c_op_bvf  = 6'h0D;
   localparam logic [5:0] c_op_ben  = 6'h0E;
   localparam logic [5:0] c_op_lw   = 6'h23;
   localparam logic [5:0] c_op_sw   = 6'h2B;

   // One-hot instruction class bit positions
   localparam int c_cls_w    = 8;
   localparam int c_cls_r    = 0;
   localparam int c_cls_j    = 1;
   localparam int c_cls_beq  = 2;
   localparam int c_cls_addi = 3;
   localparam int c_cls_bvf  = 4;
   localparam int c_cls_ben  = 5;
   localparam int c_cls_lw   = 6;
   localparam int c_cls_sw   = 7;

   // CPSR bit indices for the default 4-bit {N,Z,C,V} layout
   localparam int c_flag_v = 0;
   localparam int c_flag_c = 1;
   localparam int c_flag_z = 2;
   localparam int c_flag_n = 3;

   typedef enum logic [3:0] {
      st_fetch    = 4'd0,
      st_decode   = 4'd1,
      st_mem_addr = 4'd2,
      st_mem_rd   = 4'd3,
      st_mem_wb   = 4'd4,
      st_mem_wr   = 4'd5,
      st_exec     = 4'd6,
      st_r_wb     = 4'd7,
      st_addi_ex  = 4'd8,
      st_addi_wb  = 4'd9,
      st_branch   = 4'd10,
      st_bstat    = 4'd11,
      st_jump     = 4'd12,
      st_trap     = 4'd13
   } state_e;

   typedef enum logic [1:0] {
      aluop_add   = 2'd0,
      aluop_sub   = 2'd1,
      aluop_funct = 2'd2
   } alu_op_e;

   typedef enum logic [1:0] {
      srcb_rt      = 2'd0,
      srcb_four    = 2'd1,
      srcb_imm     = 2'd2,
      srcb_imm_sl2 = 2'd3
   } alu_src_b_e;

   typedef enum logic [1:0] {
      pcsrc_alu    = 2'd0,
      pcsrc_aluout = 2'd1,
      pcsrc_jump   = 2'd2
   } pc_source_e;

endpackage
`default_nettype wire

// File: rtl/mc_opcode_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_opcode_decode
//  Description : Exact-match opcode decoder producing a one-hot instruction
//                class vector and a legal bit for the DECODE dispatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_opcode_decode
   import mc_pkg::*;
#(
   parameter int OPCODE_W = 6
)(
   input  logic [OPCODE_W-1:0] opcode,
   output logic [c_cls_w-1:0]  cls,
   output logic                legal
);

   // Every opcode bit participates; no partial or don't-care matching.
   assign cls[c_cls_r]    = (opcode == OPCODE_W'(c_op_r));
   assign cls[c_cls_j]    = (opcode == OPCODE_W'(c_op_j));
   assign cls[c_cls_beq]  = (opcode == OPCODE_W'(c_op_beq));
   assign cls[c_cls_addi] = (opcode == OPCODE_W'(c_op_addi));
   assign cls[c_cls_bvf]  = (opcode == OPCODE_W'(c_op_bvf));
   assign cls[c_cls_ben]  = (opcode == OPCODE_W'(c_op_ben));
   assign cls[c_cls_lw]   = (opcode == OPCODE_W'(c_op_lw));
   assign cls[c_cls_sw]   = (opcode == OPCODE_W'(c_op_sw));

   assign legal = |cls;

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle FSM controller: fetch/decode/execute/memory/
//                writeback sequencing, memory-ready stalls, CPSR ownership.
//                Build option ILLEGAL_TRAP_EN: unknown opcodes lock the FSM
//                in TRAP until reset instead of being treated as NOPs.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
   import mc_pkg::*;
#(
   parameter int OPCODE_W = 6,
   parameter int FLAG_W   = 4,
   parameter int STATE_W  = 4
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic [FLAG_W-1:0]   alu_flags,
   output logic                pc_write,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          pc_source,
   output logic [FLAG_W-1:0]   cpsr,
   output logic [STATE_W-1:0]  state,
   output logic                illegal
);

   localparam int c_n_idx = FLAG_W - 1;

   state_e              r_state;
   logic [FLAG_W-1:0]   r_cpsr;
   logic [c_cls_w-1:0]  w_cls;
   logic                w_legal;

   mc_opcode_decode #(
      .OPCODE_W (OPCODE_W)
   ) u_decode (
      .opcode (opcode),
      .cls    (w_cls),
      .legal  (w_legal)
   );

   // FSM sequencing plus CPSR policy: capture on ALU-stage exits, clear on branch/jump exits.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= st_fetch;
         r_cpsr  <= '0;
      end else begin
         case (r_state)
            st_fetch: begin
               if (mem_ready) r_state <= st_decode;
            end
            st_decode: begin
               if (w_cls[c_cls_lw] || w_cls[c_cls_sw])       r_state <= st_mem_addr;
               else if (w_cls[c_cls_r])                      r_state <= st_exec;
               else if (w_cls[c_cls_addi])                   r_state <= st_addi_ex;
               else if (w_cls[c_cls_beq])                    r_state <= st_branch;
               else if (w_cls[c_cls_bvf] || w_cls[c_cls_ben]) r_state <= st_bstat;
               else if (w_cls[c_cls_j])                      r_state <= st_jump;
               else begin
`ifdef ILLEGAL_TRAP_EN
                  r_state <= st_trap;
`else
                  r_state <= st_fetch;
`endif
               end
            end
            st_mem_addr: begin
               r_cpsr  <= alu_flags;
               r_state <= w_cls[c_cls_sw] ? st_mem_wr : st_mem_rd;
            end
            st_mem_rd: begin
               if (mem_ready) r_state <= st_mem_wb;
            end
            st_mem_wb:  r_state <= st_fetch;
            st_mem_wr: begin
               if (mem_ready) r_state <= st_fetch;
            end
            st_exec: begin
               r_cpsr  <= alu_flags;
               r_state <= st_r_wb;
            end
            st_r_wb:    r_state <= st_fetch;
            st_addi_ex: begin
               r_cpsr  <= alu_flags;
               r_state <= st_addi_wb;
            end
            st_addi_wb: r_state <= st_fetch;
            st_branch, st_bstat, st_jump: begin
               r_cpsr  <= '0;
               r_state <= st_fetch;
            end
            st_trap:    r_state <= st_trap;
            default:    r_state <= st_fetch;
         endcase
      end
   end

   // State-decoded control word; everything is forced low while reset is asserted.
   always_comb begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = srcb_rt;
      alu_op     = aluop_add;
      pc_source  = pcsrc_alu;
      illegal    = 1'b0;
      if (reset_n) begin
         case (r_state)
            st_fetch: begin
               mem_read  = 1'b1;
               alu_src_b = srcb_four;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            st_decode: begin
               alu_src_b = srcb_imm_sl2;
               illegal   = ~w_legal;
            end
            st_mem_addr: begin
               alu_src_a = 1'b1;
               alu_src_b = srcb_imm;
            end
            st_mem_rd: begin
               mem_read = 1'b1;
               iord     = 1'b1;
            end
            st_mem_wb: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            st_mem_wr: begin
               mem_write = 1'b1;
               iord      = 1'b1;
            end
            st_exec: begin
               alu_src_a = 1'b1;
               alu_op    = aluop_funct;
            end
            st_r_wb: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            st_addi_ex: begin
               alu_src_a = 1'b1;
               alu_src_b = srcb_imm;
            end
            st_addi_wb: begin
               reg_write = 1'b1;
            end
            st_branch: begin
               alu_src_a = 1'b1;
               alu_op    = aluop_sub;
               pc_source = pcsrc_aluout;
               pc_write  = alu_flags[c_flag_z];
            end
            st_bstat: begin
               pc_source = pcsrc_aluout;
               pc_write  = w_cls[c_cls_ben] ? r_cpsr[c_n_idx] : r_cpsr[c_flag_v];
            end
            st_jump: begin
               pc_source = pcsrc_jump;
               pc_write  = 1'b1;
            end
            st_trap: begin
               illegal = 1'b1;
            end
            default: begin
               illegal = 1'b0;
            end
         endcase
      end
   end

   assign cpsr  = r_cpsr;
   assign state = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control: instruction-level
//                reference model, vector table, corner-case sequences and
//                randomized instruction streams.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
   import mc_pkg::*;

   localparam logic [5:0] c_opr    = 6'h00;
   localparam logic [5:0] c_opj    = 6'h02;
   localparam logic [5:0] c_opbeq  = 6'h04;
   localparam logic [5:0] c_opaddi = 6'h08;
   localparam logic [5:0] c_opbvf  = 6'h0D;
   localparam logic [5:0] c_opben  = 6'h0E;
   localparam logic [5:0] c_oplw   = 6'h23;
   localparam logic [5:0] c_opsw   = 6'h2B;
   localparam logic [5:0] c_opbad  = 6'h3F;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic [3:0] alu_flags;
   logic       pc_write, iord, mem_read, mem_write, ir_write;
   logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] cpsr, state;

   always #5 clk = ~clk;

   multicycle_control #(.OPCODE_W(6), .FLAG_W(4), .STATE_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .alu_flags(alu_flags), .pc_write(pc_write), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .cpsr(cpsr), .state(state), .illegal(illegal)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, iord, mr, mw, irw, rdst, m2r, rw, asa;
      logic [1:0] asb, aop, psrc;
      logic       ill;
      logic [3:0] cp;
   } obs_t;

   typedef struct {
      logic [5:0] op;
      logic [3:0] fl;
      int         lat;
      logic       pcw;
      logic [3:0] cp;
      string      nm;
   } vec_t;

   obs_t       w_obs;
   int         n_vec = 0;
   int         n_err = 0;
   int         cyc;
   logic [3:0] cpsr_m;
   logic       last_pcw;

   assign w_obs = {state, pc_write, iord, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
                   illegal, cpsr};

   // Control word the specification lists for each state
   function automatic obs_t exp_of(input state_e st, input logic rdy, input logic pcw,
                                   input logic ill, input logic [3:0] cp);
      obs_t e;
      e     = '0;
      e.st  = st;
      e.pcw = pcw;
      e.ill = ill;
      e.cp  = cp;
      case (st)
         st_fetch:    begin e.mr = 1'b1; e.asb = 2'd1; e.irw = rdy; end
         st_decode:   e.asb = 2'd3;
         st_mem_addr: begin e.asa = 1'b1; e.asb = 2'd2; end
         st_mem_rd:   begin e.mr = 1'b1; e.iord = 1'b1; end
         st_mem_wb:   begin e.rw = 1'b1; e.m2r = 1'b1; end
         st_mem_wr:   begin e.mw = 1'b1; e.iord = 1'b1; end
         st_exec:     begin e.asa = 1'b1; e.aop = 2'd2; end
         st_r_wb:     begin e.rw = 1'b1; e.rdst = 1'b1; end
         st_addi_ex:  begin e.asa = 1'b1; e.asb = 2'd2; end
         st_addi_wb:  e.rw = 1'b1;
         st_branch:   begin e.asa = 1'b1; e.aop = 2'd1; e.psrc = 2'd1; end
         st_bstat:    e.psrc = 2'd1;
         st_jump:     e.psrc = 2'd2;
         default:     e.psrc = 2'd0;
      endcase
      return e;
   endfunction

   function automatic logic [3:0] pf(input logic fix, input logic [3:0] ff);
      return fix ? ff : 4'($urandom);
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic chk(input obs_t e, input string nm);
      n_vec++;
      if (w_obs !== e) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, w_obs, e, $time);
      end
   endtask

   task automatic chk_val(input string nm, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   // One clock: drive, compare mid-cycle, apply CPSR rule (1 capture, 2 clear), advance
   task automatic step(input state_e st, input logic rdy, input logic [3:0] fl,
                       input logic pcw, input logic ill, input int cap, input string nm);
      mem_ready = rdy;
      alu_flags = fl;
      #3;
      chk(exp_of(st, rdy, pcw, ill, cpsr_m), nm);
      last_pcw = pc_write;
      if (cap == 1)      cpsr_m = fl;
      else if (cap == 2) cpsr_m = 4'b0000;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Instruction-level reference: expected state walk derived from the opcode
   task automatic do_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic fix, input logic [3:0] ff, output int lat);
      logic [3:0] fl;
      logic       lg;
      opcode = op;
      cyc    = 0;
      lg = (op == c_opr) || (op == c_opj) || (op == c_opbeq) || (op == c_opaddi) ||
           (op == c_opbvf) || (op == c_opben) || (op == c_oplw) || (op == c_opsw);
      for (int i = 0; i < fw; i++) step(st_fetch, 1'b0, pf(fix, ff), 1'b0, 1'b0, 0, "fetch_wait");
      step(st_fetch, 1'b1, pf(fix, ff), 1'b1, 1'b0, 0, "fetch");
      step(st_decode, rb(), pf(fix, ff), 1'b0, ~lg, 0, "decode");
      if (op == c_opr) begin
         step(st_exec, rb(), pf(fix, ff), 1'b0, 1'b0, 1, "exec");
         step(st_r_wb, rb(), pf(fix, ff), 1'b0, 1'b0, 0, "r_wb");
      end else if (op == c_opaddi) begin
         step(st_addi_ex, rb(), pf(fix, ff), 1'b0, 1'b0, 1, "addi_ex");
         step(st_addi_wb, rb(), pf(fix, ff), 1'b0, 1'b0, 0, "addi_wb");
      end else if (op == c_oplw) begin
         step(st_mem_addr, rb(), pf(fix, ff), 1'b0, 1'b0, 1, "lw_addr");
         for (int i = 0; i < mw; i++) step(st_mem_rd, 1'b0, pf(fix, ff), 1'b0, 1'b0, 0, "mem_rd_wait");
         step(st_mem_rd, 1'b1, pf(fix, ff), 1'b0, 1'b0, 0, "mem_rd");
         step(st_mem_wb, rb(), pf(fix, ff), 1'b0, 1'b0, 0, "mem_wb");
      end else if (op == c_opsw) begin
         step(st_mem_addr, rb(), pf(fix, ff), 1'b0, 1'b0, 1, "sw_addr");
         for (int i = 0; i < mw; i++) step(st_mem_wr, 1'b0, pf(fix, ff), 1'b0, 1'b0, 0, "mem_wr_wait");
         step(st_mem_wr, 1'b1, pf(fix, ff), 1'b0, 1'b0, 0, "mem_wr");
      end else if (op == c_opbeq) begin
         fl = pf(fix, ff);
         step(st_branch, rb(), fl, fl[2], 1'b0, 2, "branch");
      end else if (op == c_opbvf) begin
         step(st_bstat, rb(), pf(fix, ff), cpsr_m[0], 1'b0, 2, "bvf");
      end else if (op == c_opben) begin
         step(st_bstat, rb(), pf(fix, ff), cpsr_m[3], 1'b0, 2, "ben");
      end else if (op == c_opj) begin
         step(st_jump, rb(), pf(fix, ff), 1'b1, 1'b0, 2, "jump");
      end
      lat = cyc;
   endtask

   initial begin
      vec_t       tbl[12];
      obs_t       e;
      int         lat;
      logic [5:0] ops[$];

      tbl[0]  = '{c_opr,    4'b1000, 4, 1'b0, 4'b1000, "v_r"};
      tbl[1]  = '{c_opaddi, 4'b0001, 4, 1'b0, 4'b0001, "v_addi_v"};
      tbl[2]  = '{c_opbvf,  4'b0001, 3, 1'b1, 4'b0000, "v_bvf_taken"};
      tbl[3]  = '{c_opbvf,  4'b0000, 3, 1'b0, 4'b0000, "v_bvf_not"};
      tbl[4]  = '{c_oplw,   4'b0100, 5, 1'b0, 4'b0100, "v_lw"};
      tbl[5]  = '{c_opbeq,  4'b0000, 3, 1'b0, 4'b0000, "v_beq_nz"};
      tbl[6]  = '{c_opsw,   4'b0010, 4, 1'b0, 4'b0010, "v_sw"};
      tbl[7]  = '{c_opben,  4'b1111, 3, 1'b0, 4'b0000, "v_ben_not"};
      tbl[8]  = '{c_opaddi, 4'b1000, 4, 1'b0, 4'b1000, "v_addi_n"};
      tbl[9]  = '{c_opben,  4'b0000, 3, 1'b1, 4'b0000, "v_ben_taken"};
      tbl[10] = '{c_opbeq,  4'b0100, 3, 1'b1, 4'b0000, "v_beq_z"};
      tbl[11] = '{c_opj,    4'b0000, 3, 1'b1, 4'b0000, "v_j"};

      // Reset: outputs low while asserted, then FETCH with cleared CPSR
      reset_n   = 1'b0;
      opcode    = c_opsw;
      mem_ready = 1'b1;
      alu_flags = 4'b1111;
      cpsr_m    = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      e    = '0;
      e.st = st_fetch;
      chk(e, "reset_hold");
      reset_n = 1'b1;

      // Vector table
      for (int i = 0; i < 12; i++) begin
         do_instr(tbl[i].op, 0, 0, 1'b1, tbl[i].fl, lat);
         chk_val({tbl[i].nm, "_lat"}, lat, tbl[i].lat);
         chk_val({tbl[i].nm, "_pcw"}, int'(last_pcw), int'(tbl[i].pcw));
         chk_val({tbl[i].nm, "_cpsr"}, int'(cpsr), int'(tbl[i].cp));
      end

      // LW with three stalled MEM_RD cycles, R with fetch stalls
      do_instr(c_oplw, 0, 3, 1'b0, 4'b0000, lat);
      chk_val("lw_stall_lat", lat, 8);
      do_instr(c_opr, 2, 0, 1'b0, 4'b0000, lat);
      chk_val("r_fetch_stall_lat", lat, 6);

      // Reset during MEM_WR wait
      opcode = c_opsw;
      cyc    = 0;
      step(st_fetch, 1'b1, 4'b0000, 1'b1, 1'b0, 0, "rs_fetch");
      step(st_decode, 1'b1, 4'b0000, 1'b0, 1'b0, 0, "rs_decode");
      step(st_mem_addr, 1'b1, 4'b0110, 1'b0, 1'b0, 1, "rs_addr");
      step(st_mem_wr, 1'b0, 4'b0000, 1'b0, 1'b0, 0, "rs_wr_wait");
      reset_n   = 1'b0;
      mem_ready = 1'b0;
      #3;
      e    = '0;
      e.st = st_mem_wr;
      e.cp = 4'b0110;
      chk(e, "rs_reset_cycle");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cpsr_m  = 4'b0000;
      step(st_fetch, 1'b0, 4'b0000, 1'b0, 1'b0, 0, "rs_after");

      // Unknown opcode
      do_instr(c_opaddi, 0, 0, 1'b1, 4'b1010, lat);
      do_instr(c_opbad, 0, 0, 1'b0, 4'b0000, lat);
      chk_val("bad_lat", lat, 2);
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) step(st_trap, rb(), 4'($urandom), 1'b0, 1'b1, 0, "trap_hold");
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cpsr_m  = 4'b0000;
      step(st_fetch, 1'b0, 4'b0000, 1'b0, 1'b0, 0, "trap_after_reset");
`else
      chk_val("bad_cpsr_kept", int'(cpsr), 10);
      do_instr(c_opj, 0, 0, 1'b0, 4'b0000, lat);
      chk_val("bad_then_j_lat", lat, 3);
`endif

      // Randomized instruction stream
      ops = '{c_opr, c_opj, c_opbeq, c_opaddi, c_opbvf, c_opben, c_oplw, c_opsw};
`ifndef ILLEGAL_TRAP_EN
      ops.push_back(c_opbad);
      ops.push_back(6'h24);
      ops.push_back(6'h0C);
`endif
      for (int i = 0; i < 300; i++) begin
         do_instr(ops[$urandom_range(0, ops.size() - 1)], int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), 1'b0, 4'b0000, lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
